vga_plot_engine: RTL

Responder for the control path's pixel-plot requests. Detects each new plot (or clear) request, captures the selected colour and coordinate register values, and drives a single-pixel write port on the framebuffer/VGA adapter. Clear requests sweep the whole screen one pixel per cycle. Sits between the register file read ports (colour/coord selects) and the VGA adapter write interface.

---
 rtl/vga_plot_engine_pkg.sv | 22 ++
 rtl/vga_clear_sweep.sv | 35 +++
 rtl/vga_plot_engine.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/vga_plot_engine_pkg.sv
// rtl/vga_plot_engine_pkg.sv - shared geometry, coord field layout and state encoding
package vga_plot_engine_pkg;

   localparam int WIDTH_DEF    = 160;
   localparam int HEIGHT_DEF   = 120;
   localparam int X_W_DEF      = 8;
   localparam int Y_W_DEF      = 7;
   localparam int COLOUR_W_DEF = 3;

   // Coordinate register layout agreed with the control path
   localparam int COORD_X_MSB = 15;
   localparam int COORD_X_LSB = 8;
   localparam int COORD_Y_MSB = 7;
   localparam int COORD_Y_LSB = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLOT  = 2'd1,
      CLEAR = 2'd2
   } plot_state_t;

endpackage

// File: rtl/vga_clear_sweep.sv
// rtl/vga_clear_sweep.sv - raster x/y counter, one pixel per enabled cycle
module vga_clear_sweep
   import vga_plot_engine_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF,
   parameter int X_W    = X_W_DEF,
   parameter int Y_W    = Y_W_DEF
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           start,
   input  logic           en,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   assign last = (int'(x) == WIDTH - 1) && (int'(y) == HEIGHT - 1);

   always_ff @(posedge clock) begin
      if (!resetn || start) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (int'(x) == WIDTH - 1) begin
            x <= '0;
            y <= (int'(y) == HEIGHT - 1) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vga_plot_engine.sv
// rtl/vga_plot_engine.sv - edge-triggered plot/clear responder driving the VGA write port
module vga_plot_engine
   import vga_plot_engine_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int HEIGHT   = HEIGHT_DEF,
   parameter int X_W      = X_W_DEF,
   parameter int Y_W      = Y_W_DEF,
   parameter int COLOUR_W = COLOUR_W_DEF,
   parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic                plot_req,
   input  logic                clear_req,
   input  logic [15:0]         colour_value,
   input  logic [15:0]         coord_value,
   output logic                busy,
   output logic                plot_done,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_writeEn,
   output logic                range_err,
   output logic                overrun_err
);

   plot_state_t state, state_next;

   logic                plot_req_d, clear_req_d;
   logic                new_plot, new_clear;
   logic [7:0]          cur_x, cur_y, pend_x, pend_y;
   logic [COLOUR_W-1:0] cur_colour, pend_colour;
   logic                pend_valid, pend_clear;
   logic [7:0]          coord_x, coord_y;
   logic [COLOUR_W-1:0] colour_in;
   logic                in_range;
   logic                sweep_start, sweep_last;
   logic [X_W-1:0]      sweep_x;
   logic [Y_W-1:0]      sweep_y;
   logic                cap_new, cap_pend, pend_pop, store_plot, store_clear, drop, range_hit;
   logic                unused_colour_bits;

   assign new_plot  = plot_req & ~plot_req_d;
   assign new_clear = clear_req & ~clear_req_d;
   assign coord_x   = coord_value[COORD_X_MSB:COORD_X_LSB];
   assign coord_y   = coord_value[COORD_Y_MSB:COORD_Y_LSB];
   assign colour_in = colour_value[COLOUR_W-1:0];
   assign unused_colour_bits = ^colour_value[15:COLOUR_W];
   assign in_range  = (int'(cur_x) < WIDTH) && (int'(cur_y) < HEIGHT);
   assign busy      = (state != IDLE) | pend_valid;

   vga_clear_sweep #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .X_W   (X_W),
      .Y_W   (Y_W)
   ) u_sweep (
      .clock (clock),
      .resetn(resetn),
      .start (sweep_start),
      .en    (state == CLEAR),
      .x     (sweep_x),
      .y     (sweep_y),
      .last  (sweep_last)
   );

   always_ff @(posedge clock) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next  = state;
      sweep_start = 1'b0;
      cap_new     = 1'b0;
      cap_pend    = 1'b0;
      pend_pop    = 1'b0;
      store_plot  = 1'b0;
      store_clear = 1'b0;
      drop        = 1'b0;
      range_hit   = 1'b0;
      plot_done   = 1'b0;
      vga_writeEn = 1'b0;
      vga_x       = '0;
      vga_y       = '0;
      vga_colour  = '0;
      case (state)
         IDLE: begin
            // Clear wins a tie; the simultaneous plot queues behind it
            if (new_clear) begin
               state_next  = CLEAR;
               sweep_start = 1'b1;
               if (new_plot) begin
                  if (pend_valid) drop = 1'b1;
                  else            store_plot = 1'b1;
               end
            end else if (new_plot) begin
               state_next = PLOT;
               cap_new    = 1'b1;
            end else if (pend_valid) begin
               pend_pop    = 1'b1;
               cap_pend    = ~pend_clear;
               sweep_start = pend_clear;
               state_next  = pend_clear ? CLEAR : PLOT;
            end
         end
         PLOT: begin
            plot_done  = 1'b1;
            state_next = IDLE;
            if (in_range) begin
               vga_writeEn = 1'b1;
               vga_x       = cur_x[X_W-1:0];
               vga_y       = cur_y[Y_W-1:0];
               vga_colour  = cur_colour;
            end else begin
               range_hit = 1'b1;
            end
         end
         CLEAR: begin
            vga_writeEn = 1'b1;
            vga_x       = sweep_x;
            vga_y       = sweep_y;
            vga_colour  = CLEAR_COLOUR;
            if (sweep_last) begin
               plot_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (state != IDLE && (new_clear || new_plot)) begin
         if (pend_valid) begin
            drop = 1'b1;
         end else if (new_clear) begin
            store_clear = 1'b1;
            drop        = new_plot;
         end else begin
            store_plot = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         plot_req_d  <= 1'b0;
         clear_req_d <= 1'b0;
         cur_x       <= '0;
         cur_y       <= '0;
         cur_colour  <= '0;
         pend_valid  <= 1'b0;
         pend_clear  <= 1'b0;
         pend_x      <= '0;
         pend_y      <= '0;
         pend_colour <= '0;
         range_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         plot_req_d  <= plot_req;
         clear_req_d <= clear_req;
         if (cap_new) begin
            cur_x      <= coord_x;
            cur_y      <= coord_y;
            cur_colour <= colour_in;
         end else if (cap_pend) begin
            cur_x      <= pend_x;
            cur_y      <= pend_y;
            cur_colour <= pend_colour;
         end
         if (store_plot || store_clear) begin
            pend_valid  <= 1'b1;
            pend_clear  <= store_clear;
            pend_x      <= coord_x;
            pend_y      <= coord_y;
            pend_colour <= colour_in;
         end else if (pend_pop) begin
            pend_valid <= 1'b0;
         end
         if (drop)      overrun_err <= 1'b1;
         if (range_hit) range_err   <= 1'b1;
      end
   end

endmodule
